// File: rtl/water_level_pkg.sv
// Shared level encoding for the tank water-level monitor: level enum,
// one-hot indicator codes and the decode helpers used by the top level.
package water_level_pkg;

  typedef enum logic [1:0] {
    LVL_EMPTY  = 2'd0,
    LVL_LOW    = 2'd1,
    LVL_MEDIUM = 2'd2,
    LVL_HIGH   = 2'd3
  } level_e;

  localparam logic [3:0] IND_NONE   = 4'b0000;
  localparam logic [3:0] IND_EMPTY  = 4'b0001;
  localparam logic [3:0] IND_LOW    = 4'b0010;
  localparam logic [3:0] IND_MEDIUM = 4'b0100;
  localparam logic [3:0] IND_HIGH   = 4'b1000;

  function automatic logic [3:0] level_to_ind(input level_e lvl);
    logic [3:0] ind;
    case (lvl)
      LVL_EMPTY:  ind = IND_EMPTY;
      LVL_LOW:    ind = IND_LOW;
      LVL_MEDIUM: ind = IND_MEDIUM;
      LVL_HIGH:   ind = IND_HIGH;
      default:    ind = IND_NONE;
    endcase
    return ind;
  endfunction

  // Vector is {high, medium, low, empty}; the highest wet band wins.
  function automatic level_e decode_level(input logic [3:0] v);
    level_e lvl;
    if (v[3])      lvl = LVL_HIGH;
    else if (v[2]) lvl = LVL_MEDIUM;
    else if (v[1]) lvl = LVL_LOW;
    else           lvl = LVL_EMPTY;
    return lvl;
  endfunction

endpackage

// File: rtl/water_level_indicator_debounce.sv
// Multi-bit synchronizer plus stability filter. Emits a one-cycle strobe
// when the synchronized vector has held for DEBOUNCE_CYCLES edges.
module sensor_debounce #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] acc_vec,
  output logic             acc_stb
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  generate
    if (SYNC_STAGES < 2)     begin : g_bad_sync $error("SYNC_STAGES must be >= 2"); end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb  $error("DEBOUNCE_CYCLES must be >= 1"); end
  endgenerate

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [SYNC_STAGES-1:0]            vld_pipe;
  logic [WIDTH-1:0]                  cand;
  logic                              cand_vld;
  logic [CW-1:0]                     cnt;
  logic [WIDTH-1:0]                  sync_v;
  logic                              sync_vld;
  logic                              changed;

  assign sync_v   = sync_q[SYNC_STAGES-1];
  // Synchronizer contents are reset values, not pin samples, until this rises.
  assign sync_vld = vld_pipe[SYNC_STAGES-1];
  assign changed  = sync_vld && (!cand_vld || (sync_v != cand));
  assign acc_vec  = sync_v;

  generate
    if (DEBOUNCE_CYCLES == 1) begin : g_nofilt
      assign acc_stb = changed;
    end else begin : g_filt
      assign acc_stb = sync_vld && cand_vld && (sync_v == cand) &&
                       (cnt == CW'(DEBOUNCE_CYCLES - 2));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      vld_pipe <= '0;
      cand     <= '0;
      cand_vld <= 1'b0;
      cnt      <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], din};
      vld_pipe <= {vld_pipe[SYNC_STAGES-2:0], 1'b1};
      if (changed) begin
        cand     <= sync_v;
        cand_vld <= 1'b1;
        cnt      <= '0;
      end else if (sync_vld && (cnt != CNT_MAX)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/water_level_indicator.sv
// Tank level monitor: debounced band sensors -> one-hot level indicator,
// fault flag for non-one-hot readings, and pump enable with hysteresis.
module water_level_indicator
  import water_level_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor_empty,
  input  logic       sensor_low,
  input  logic       sensor_medium,
  input  logic       sensor_high,
  output logic [3:0] indicator,
  output logic       pump_on,
  output logic       sensor_fault
);

  logic [3:0] acc_vec;
  logic       acc_stb;
  level_e     lvl;
  logic       none_set;
  logic       one_hot;

  sensor_debounce #(
    .WIDTH          (4),
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .din    ({sensor_high, sensor_medium, sensor_low, sensor_empty}),
    .acc_vec(acc_vec),
    .acc_stb(acc_stb)
  );

  assign lvl      = decode_level(acc_vec);
  assign none_set = (acc_vec == 4'b0000);
  assign one_hot  = !none_set && ((acc_vec & (acc_vec - 4'd1)) == 4'b0000);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      indicator    <= IND_NONE;
      pump_on      <= 1'b0;
      sensor_fault <= 1'b0;
    end else if (acc_stb) begin
      sensor_fault <= !one_hot;
      // An all-dry reading carries no level, so display and pump hold.
      if (!none_set) begin
        indicator <= level_to_ind(lvl);
        case (lvl)
          LVL_EMPTY, LVL_LOW: pump_on <= 1'b1;
          LVL_HIGH:           pump_on <= 1'b0;
          default:            pump_on <= pump_on;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_water_level_indicator.sv
// Directed bench for water_level_indicator with default parameters
// (pin change visible on outputs exactly 6 cycles later).
module tb_water_level_indicator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_e = 1'b0, s_l = 1'b0, s_m = 1'b0, s_h = 1'b0;
  logic [3:0] indicator;
  logic       pump_on;
  logic       sensor_fault;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  water_level_indicator #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .sensor_empty (s_e),
    .sensor_low   (s_l),
    .sensor_medium(s_m),
    .sensor_high  (s_h),
    .indicator    (indicator),
    .pump_on      (pump_on),
    .sensor_fault (sensor_fault)
  );

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_pins(input logic [3:0] v);
    {s_h, s_m, s_l, s_e} = v;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    set_pins(4'b0100);
    tick(2);
    checks++;
    if ({indicator, pump_on, sensor_fault} !== 6'b0000_0_0) begin
      errors++;
      $display("FAIL reset_state: got ind=%b pump=%b fault=%b, want 0000/0/0", indicator, pump_on, sensor_fault);
    end
    set_pins(4'b0000);
    rst = 1'b0;
    tick(5);
    checks++;
    if (sensor_fault !== 1'b0) begin
      errors++;
      $display("FAIL dry_fault_early: got fault=%b at cycle 5, want 0", sensor_fault);
    end
    tick(1);
    checks++;
    if ({indicator, pump_on, sensor_fault} !== 6'b0000_0_1) begin
      errors++;
      $display("FAIL dry_fault_on: got ind=%b pump=%b fault=%b, want 0000/0/1", indicator, pump_on, sensor_fault);
    end
    tick(14);
    checks++;
    if ({indicator, pump_on, sensor_fault} !== 6'b0000_0_1) begin
      errors++;
      $display("FAIL dry_fault_hold: got ind=%b pump=%b fault=%b, want 0000/0/1", indicator, pump_on, sensor_fault);
    end
  endtask

  // empty, low, medium, high repeated: pump on for empty/low/medium, off at high;
  // before each acceptance the previous level is still shown.
  task automatic test_fill;
    logic [3:0] prev_ind, exp_ind;
    logic       prev_pump, exp_pump;
    prev_ind  = 4'b0000;
    prev_pump = 1'b0;
    for (int pass = 0; pass < 4; pass++) begin
      for (int i = 0; i < 4; i++) begin
        exp_ind  = 4'b0001 << i;
        exp_pump = (i != 3);
        set_pins(exp_ind);
        tick(5);
        checks++;
        if (indicator !== prev_ind || pump_on !== prev_pump) begin
          errors++;
          $display("FAIL fill_pre p%0d s%0d: got ind=%b pump=%b, want %b/%b", pass, i, indicator, pump_on, prev_ind, prev_pump);
        end
        tick(1);
        checks++;
        if (indicator !== exp_ind || pump_on !== exp_pump || sensor_fault !== 1'b0) begin
          errors++;
          $display("FAIL fill_acc p%0d s%0d: got ind=%b pump=%b fault=%b, want %b/%b/0", pass, i, indicator, pump_on, sensor_fault, exp_ind, exp_pump);
        end
        tick(14);
        prev_ind  = exp_ind;
        prev_pump = exp_pump;
      end
    end
  endtask

  task automatic test_drain;
    set_pins(4'b0100);
    tick(6);
    checks++;
    if (indicator !== 4'b0100 || pump_on !== 1'b0) begin
      errors++;
      $display("FAIL drain_medium: got ind=%b pump=%b, want 0100/0", indicator, pump_on);
    end
    tick(14);
    set_pins(4'b0010);
    tick(5);
    checks++;
    if (pump_on !== 1'b0) begin
      errors++;
      $display("FAIL drain_low_pre: got pump=%b, want 0", pump_on);
    end
    tick(1);
    checks++;
    if (indicator !== 4'b0010 || pump_on !== 1'b1 || sensor_fault !== 1'b0) begin
      errors++;
      $display("FAIL drain_low: got ind=%b pump=%b fault=%b, want 0010/1/0", indicator, pump_on, sensor_fault);
    end
    tick(14);
  endtask

  task automatic test_glitch;
    bit bad;
    set_pins(4'b1000);
    tick(3);
    set_pins(4'b0010);
    bad = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick(1);
      if (indicator !== 4'b0010 || pump_on !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL glitch3_filtered: got ind=%b pump=%b, want 0010/1 throughout", indicator, pump_on);
    end
    set_pins(4'b1000);
    tick(4);
    set_pins(4'b0010);
    tick(1);
    checks++;
    if (indicator !== 4'b0010) begin
      errors++;
      $display("FAIL glitch4_pre: got ind=%b, want 0010", indicator);
    end
    tick(1);
    checks++;
    if (indicator !== 4'b1000 || pump_on !== 1'b0) begin
      errors++;
      $display("FAIL glitch4_acc: got ind=%b pump=%b, want 1000/0", indicator, pump_on);
    end
    tick(3);
    checks++;
    if (indicator !== 4'b1000) begin
      errors++;
      $display("FAIL glitch4_hold: got ind=%b, want 1000", indicator);
    end
    tick(1);
    checks++;
    if (indicator !== 4'b0010 || pump_on !== 1'b1) begin
      errors++;
      $display("FAIL glitch4_back: got ind=%b pump=%b, want 0010/1", indicator, pump_on);
    end
    tick(14);
  endtask

  task automatic test_multi;
    set_pins(4'b1010);
    tick(5);
    checks++;
    if (indicator !== 4'b0010 || sensor_fault !== 1'b0) begin
      errors++;
      $display("FAIL multi_pre: got ind=%b fault=%b, want 0010/0", indicator, sensor_fault);
    end
    tick(1);
    checks++;
    if (indicator !== 4'b1000 || pump_on !== 1'b0 || sensor_fault !== 1'b1) begin
      errors++;
      $display("FAIL multi_acc: got ind=%b pump=%b fault=%b, want 1000/0/1", indicator, pump_on, sensor_fault);
    end
    tick(14);
    set_pins(4'b0010);
    tick(6);
    checks++;
    if (indicator !== 4'b0010 || pump_on !== 1'b1 || sensor_fault !== 1'b0) begin
      errors++;
      $display("FAIL multi_clear: got ind=%b pump=%b fault=%b, want 0010/1/0", indicator, pump_on, sensor_fault);
    end
    tick(14);
  endtask

  task automatic test_none;
    set_pins(4'b0000);
    tick(6);
    checks++;
    if (indicator !== 4'b0010 || pump_on !== 1'b1 || sensor_fault !== 1'b1) begin
      errors++;
      $display("FAIL none_hold: got ind=%b pump=%b fault=%b, want 0010/1/1", indicator, pump_on, sensor_fault);
    end
    tick(14);
    set_pins(4'b0100);
    tick(6);
    checks++;
    if (indicator !== 4'b0100 || pump_on !== 1'b1 || sensor_fault !== 1'b0) begin
      errors++;
      $display("FAIL none_to_medium: got ind=%b pump=%b fault=%b, want 0100/1/0", indicator, pump_on, sensor_fault);
    end
    tick(14);
  endtask

  task automatic test_reset_mid;
    set_pins(4'b1000);
    tick(2);
    rst = 1'b1;
    #1;
    checks++;
    if ({indicator, pump_on, sensor_fault} !== 6'b0000_0_0) begin
      errors++;
      $display("FAIL rst_async: got ind=%b pump=%b fault=%b, want 0000/0/0", indicator, pump_on, sensor_fault);
    end
    tick(2);
    rst = 1'b0;
    tick(5);
    checks++;
    if (indicator !== 4'b0000 || pump_on !== 1'b0) begin
      errors++;
      $display("FAIL rst_release_pre: got ind=%b pump=%b, want 0000/0", indicator, pump_on);
    end
    tick(1);
    checks++;
    if (indicator !== 4'b1000 || pump_on !== 1'b0 || sensor_fault !== 1'b0) begin
      errors++;
      $display("FAIL rst_release_acc: got ind=%b pump=%b fault=%b, want 1000/0/0", indicator, pump_on, sensor_fault);
    end
    tick(4);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_glitch();
    test_multi();
    test_none();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
